// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues same-cycle instruction reads and queues
// {pc, instruction} pairs in a small circular buffer for decode; redirects flush the buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic        imemreq_val,
    output logic [31:0] imemreq_addr,
    input  logic [31:0] imemresp_data,
    input  logic        redirect_val,
    input  logic [31:0] redirect_pc,
    output logic        inst_val,
    input  logic        inst_rdy,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {StIdle, StRun} state_t;

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [31:0]      buf_data_q [DEPTH];
    logic [31:0]      buf_pc_q   [DEPTH];

    logic full;
    logic deq;
    logic fire;

    assign full     = (count_q == CNT_W'(DEPTH));
    // A redirect hides the head so nothing stale is consumed in the flush cycle.
    assign inst_val = (count_q != '0) & ~redirect_val;
    assign deq      = inst_val & inst_rdy;
    assign fire     = (state_q == StRun) & ~redirect_val & (~full | deq);

    assign imemreq_val  = fire;
    assign imemreq_addr = pc_q;
    assign inst_data    = buf_data_q[head_q];
    assign inst_pc      = buf_pc_q[head_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else begin
            state_q <= fetch_en ? StRun : StIdle;
            if (redirect_val) begin
                count_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                pc_q    <= {redirect_pc[31:2], 2'b00};
            end else begin
                if (fire) begin
                    buf_data_q[tail_q] <= imemresp_data;
                    buf_pc_q[tail_q]   <= pc_q;
                    tail_q             <= tail_q + PTR_W'(1);
                    pc_q               <= pc_q + 32'd4;
                end
                if (deq) begin
                    head_q <= head_q + PTR_W'(1);
                end
                if (fire && !deq) begin
                    count_q <= count_q + CNT_W'(1);
                end else if (deq && !fire) begin
                    count_q <= count_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        assert (count_q <= CNT_W'(DEPTH));
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random stimulus, checked against a
// queue-based reference model of the fetch buffer.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        imemreq_val;
    logic [31:0] imemreq_addr;
    logic [31:0] imemresp_data;
    logic        redirect_val;
    logic [31:0] redirect_pc;
    logic        inst_val;
    logic        inst_rdy;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .imemreq_val  (imemreq_val),
        .imemreq_addr (imemreq_addr),
        .imemresp_data(imemresp_data),
        .redirect_val (redirect_val),
        .redirect_pc  (redirect_pc),
        .inst_val     (inst_val),
        .inst_rdy     (inst_rdy),
        .inst_data    (inst_data),
        .inst_pc      (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word at address 4*k holds 0xA0 + k.
    function automatic logic [31:0] memf(input logic [31:0] addr);
        return 32'hA0 + {2'b00, addr[31:2]};
    endfunction

    assign imemresp_data = memf(imemreq_addr);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_run;
    int          n_pass;
    int          n_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_pc  = RESET_PC;
        m_run = 1'b0;
    endtask

    // One cycle: drive inputs just after the falling edge, check, then advance the model.
    task automatic step(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
        bit exp_val;
        bit exp_deq;
        bit exp_fire;
        fetch_en     = en;
        inst_rdy     = rdy;
        redirect_val = rv;
        redirect_pc  = rpc;
        #1;
        exp_val  = (q.size() != 0) && !rv;
        exp_deq  = exp_val && rdy;
        exp_fire = m_run && !rv && ((q.size() < DEPTH) || exp_deq);
        chk("imemreq_val", {31'd0, imemreq_val}, {31'd0, exp_fire});
        chk("imemreq_addr", imemreq_addr, m_pc);
        chk("inst_val", {31'd0, inst_val}, {31'd0, exp_val});
        if (exp_val) begin
            chk("inst_pc", inst_pc, q[0].pc);
            chk("inst_data", inst_data, q[0].data);
        end
        @(posedge clk);
        m_run = en;
        if (rv) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (exp_deq) void'(q.pop_front());
            if (exp_fire) begin
                q.push_back('{pc: m_pc, data: memf(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_inst_val", {31'd0, inst_val}, 32'd0);
        chk("rst_imemreq_val", {31'd0, imemreq_val}, 32'd0);
        chk("rst_pc", imemreq_addr, RESET_PC);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        fetch_en     = 1'b0;
        inst_rdy     = 1'b0;
        redirect_val = 1'b0;
        redirect_pc  = '0;

        // Reset and streaming start at full throughput.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, '0);

        // Backpressure from the start: buffer fills, pc holds, then release.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0);
        chk("bp_pc_held", imemreq_addr, 32'd8);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);

        // Redirect flush with a full buffer and decode ready in the same cycle.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        chk("flush_empty", {31'd0, inst_val}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);

        // Misaligned redirect target and PC wrap, plus back-to-back redirects.
        step(1'b1, 1'b1, 1'b1, 32'h1234_5678);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);

        // Pause: draining continues without new requests.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);

        // Redirect while idle, then asynchronous reset between edges with a full buffer.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_inst_val", {31'd0, inst_val}, 32'd0);
        chk("async_imemreq_val", {31'd0, imemreq_val}, 32'd0);
        chk("async_pc", imemreq_addr, RESET_PC);
        @(negedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(9) != 0), ($urandom_range(1) == 1),
                 ($urandom_range(9) == 0), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
